vga_bounce_gen: RTL and testbench

VGA_BOUNCE_GEN -- requirements
Module: vga_bounce_gen

---
 rtl/vga_pkg.sv | 18 +
 rtl/vga_axis_mover.sv | 40 ++++
 rtl/vga_bounce_gen.sv | 155 +++++++++++++++
 tb/tb_vga_bounce_gen.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and constants for the bouncing-box pattern generator.
package vga_pkg;

    typedef enum logic [1:0] {
        WAIT_VBLANK = 2'd0,
        MOVE        = 2'd1,
        WAIT_FRAME  = 2'd2
    } state_t;

    // Colours packed as {R, G, B}.
    localparam logic [23:0] BOX_RGB   = 24'hFFFF00;
    localparam logic [23:0] BG_RGB    = 24'h000080;
    localparam logic [23:0] BLANK_RGB = 24'h000000;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;

endpackage

// File: rtl/vga_axis_mover.sv
// One axis of box motion: advances pos by step, clamping and reversing at 0 or limit.
// limit is the largest legal position (active size minus box size).
module vga_axis_mover (
    input  logic [15:0] pos,
    input  logic        dir,
    input  logic [15:0] limit,
    input  logic [15:0] step,
    output logic [15:0] next_pos,
    output logic        next_dir,
    output logic        hit
);

    logic [16:0] fwd_sum;

    always_comb begin
        // 17-bit sum so a position near the top of the range cannot wrap past the limit test.
        fwd_sum  = {1'b0, pos} + {1'b0, step};
        next_pos = pos;
        next_dir = dir;
        hit      = 1'b0;
        if (dir) begin
            if (fwd_sum > {1'b0, limit}) begin
                next_pos = limit;
                next_dir = 1'b0;
                hit      = 1'b1;
            end else begin
                next_pos = fwd_sum[15:0];
            end
        end else begin
            if (pos < step) begin
                next_pos = 16'd0;
                next_dir = 1'b1;
                hit      = 1'b1;
            end else begin
                next_pos = pos - step;
            end
        end
    end

endmodule

// File: rtl/vga_bounce_gen.sv
// Bouncing-box test pattern: paints a square over a background and moves it once per frame.
// Debug outputs expose the FSM state and the box position/direction registers.
module vga_bounce_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int BOX_SIZE = 32,
    parameter int STEP     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        v_enable,
    input  logic [15:0] horiz_count,
    input  logic [15:0] vert_count,
    output logic [7:0]  R,
    output logic [7:0]  G,
    output logic [7:0]  B,
    output logic        frame_tick,
    output logic [7:0]  bounce_count,
    output logic [1:0]  dbg_state,
    output logic [15:0] dbg_x_pos,
    output logic [15:0] dbg_y_pos,
    output logic        dbg_dx,
    output logic        dbg_dy
);

    localparam logic [15:0] H_ACT   = 16'(H_ACTIVE);
    localparam logic [15:0] V_ACT   = 16'(V_ACTIVE);
    localparam logic [15:0] BOX     = 16'(BOX_SIZE);
    localparam logic [15:0] STEP_W  = 16'(STEP);
    localparam logic [15:0] X_LIMIT = 16'(H_ACTIVE - BOX_SIZE);
    localparam logic [15:0] Y_LIMIT = 16'(V_ACTIVE - BOX_SIZE);

    state_t      state_q, state_d;
    logic [15:0] x_pos_q, x_pos_d;
    logic [15:0] y_pos_q, y_pos_d;
    logic        dx_q, dx_d;
    logic        dy_q, dy_d;
    logic [7:0]  bounce_q, bounce_d;
    logic [23:0] rgb_q, rgb_d;

    logic [15:0] x_next, y_next;
    logic        dx_next, dy_next;
    logic        x_hit, y_hit;

    logic        active;
    logic        box_hit;
    logic [16:0] x_end, y_end;

    vga_axis_mover u_x_mover (
        .pos      (x_pos_q),
        .dir      (dx_q),
        .limit    (X_LIMIT),
        .step     (STEP_W),
        .next_pos (x_next),
        .next_dir (dx_next),
        .hit      (x_hit)
    );

    vga_axis_mover u_y_mover (
        .pos      (y_pos_q),
        .dir      (dy_q),
        .limit    (Y_LIMIT),
        .step     (STEP_W),
        .next_pos (y_next),
        .next_dir (dy_next),
        .hit      (y_hit)
    );

    // Pixel path: box edges are widened to 17 bits so x_pos+BOX_SIZE never truncates.
    always_comb begin
        x_end   = {1'b0, x_pos_q} + {1'b0, BOX};
        y_end   = {1'b0, y_pos_q} + {1'b0, BOX};
        active  = (horiz_count < H_ACT) && (vert_count < V_ACT);
        box_hit = (horiz_count >= x_pos_q) && ({1'b0, horiz_count} < x_end) &&
                  (vert_count >= y_pos_q) && ({1'b0, vert_count} < y_end);
        rgb_d   = rgb_q;
        if (v_enable) begin
            if (!active) begin
                rgb_d = BLANK_RGB;
            end else if (box_hit) begin
                rgb_d = BOX_RGB;
            end else begin
                rgb_d = BG_RGB;
            end
        end
    end

    // Frame FSM: WAIT_FRAME blocks a second update while vert_count sits at V_ACTIVE.
    always_comb begin
        state_d    = state_q;
        x_pos_d    = x_pos_q;
        y_pos_d    = y_pos_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        bounce_d   = bounce_q;
        frame_tick = 1'b0;
        case (state_q)
            WAIT_VBLANK: begin
                if (v_enable && (horiz_count == 16'd0) && (vert_count == V_ACT)) begin
                    state_d = MOVE;
                end
            end
            MOVE: begin
                frame_tick = 1'b1;
                state_d    = WAIT_FRAME;
                x_pos_d    = x_next;
                y_pos_d    = y_next;
                dx_d       = dx_next;
                dy_d       = dy_next;
                bounce_d   = bounce_q + {7'd0, (x_hit | y_hit)};
            end
            WAIT_FRAME: begin
                if (v_enable && (vert_count == 16'd0)) begin
                    state_d = WAIT_VBLANK;
                end
            end
            default: begin
                state_d = WAIT_VBLANK;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= WAIT_VBLANK;
            x_pos_q  <= 16'd0;
            y_pos_q  <= 16'd0;
            dx_q     <= 1'b1;
            dy_q     <= 1'b1;
            bounce_q <= 8'd0;
            rgb_q    <= BLANK_RGB;
        end else begin
            state_q  <= state_d;
            x_pos_q  <= x_pos_d;
            y_pos_q  <= y_pos_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            bounce_q <= bounce_d;
            rgb_q    <= rgb_d;
        end
    end

    assign R            = rgb_q[23:16];
    assign G            = rgb_q[15:8];
    assign B            = rgb_q[7:0];
    assign bounce_count = bounce_q;
    assign dbg_state    = state_q;
    assign dbg_x_pos    = x_pos_q;
    assign dbg_y_pos    = y_pos_q;
    assign dbg_dx       = dx_q;
    assign dbg_dy       = dy_q;

endmodule

// File: tb/tb_vga_bounce_gen.sv
// Self-checking bench for vga_bounce_gen: default-size instance plus a small
// instance (11x11 screen, 4-pixel box, step 3) that reaches the x=y=1 corner case.
module tb_vga_bounce_gen;

    logic        clk;
    logic        rst;
    logic        ven;
    logic [15:0] horiz, vert;
    logic [7:0]  r, g, b;
    logic        frame_tick;
    logic [7:0]  bounce;
    logic [1:0]  st;
    logic [15:0] xp, yp;
    logic        dxo, dyo;

    logic        sm_en;
    logic [15:0] sm_h, sm_v;
    logic [7:0]  sm_r, sm_g, sm_b;
    logic        sm_tick;
    logic [7:0]  sm_bounce;
    logic [1:0]  sm_st;
    logic [15:0] sm_x, sm_y;
    logic        sm_dx, sm_dy;

    int checks = 0;
    int errors = 0;
    int tick_cnt;

    logic [23:0] exp_q[$];
    logic [23:0] last_exp;

    int m_x, m_y, m_bounce;
    logic m_dx, m_dy;

    vga_bounce_gen dut (
        .clk(clk), .reset(rst), .v_enable(ven), .horiz_count(horiz), .vert_count(vert),
        .R(r), .G(g), .B(b), .frame_tick(frame_tick), .bounce_count(bounce),
        .dbg_state(st), .dbg_x_pos(xp), .dbg_y_pos(yp), .dbg_dx(dxo), .dbg_dy(dyo)
    );

    vga_bounce_gen #(.H_ACTIVE(11), .V_ACTIVE(11), .BOX_SIZE(4), .STEP(3)) dut_small (
        .clk(clk), .reset(rst), .v_enable(sm_en), .horiz_count(sm_h), .vert_count(sm_v),
        .R(sm_r), .G(sm_g), .B(sm_b), .frame_tick(sm_tick), .bounce_count(sm_bounce),
        .dbg_state(sm_st), .dbg_x_pos(sm_x), .dbg_y_pos(sm_y), .dbg_dx(sm_dx), .dbg_dy(sm_dy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] color_of(input int h, input int v);
        if (h >= 640 || v >= 480) return 24'h000000;
        if (h >= m_x && h < m_x + 32 && v >= m_y && v < m_y + 32) return 24'hFFFF00;
        return 24'h000080;
    endfunction

    task automatic model_reset;
        m_x = 0; m_y = 0; m_dx = 1'b1; m_dy = 1'b1; m_bounce = 0;
        exp_q.delete();
        last_exp = 24'h0;
    endtask

    task automatic model_step;
        logic hit;
        hit = 1'b0;
        if (m_dx) begin
            if (m_x + 32 + 2 > 640) begin m_x = 608; m_dx = 1'b0; hit = 1'b1; end
            else m_x = m_x + 2;
        end else begin
            if (m_x < 2) begin m_x = 0; m_dx = 1'b1; hit = 1'b1; end
            else m_x = m_x - 2;
        end
        if (m_dy) begin
            if (m_y + 32 + 2 > 480) begin m_y = 448; m_dy = 1'b0; hit = 1'b1; end
            else m_y = m_y + 2;
        end else begin
            if (m_y < 2) begin m_y = 0; m_dy = 1'b1; hit = 1'b1; end
            else m_y = m_y - 2;
        end
        if (hit) m_bounce = (m_bounce + 1) % 256;
    endtask

    // driver: one clock of pixel input; scoreboard pops the colour one edge later
    task automatic apply(input int h, input int v, input logic en);
        logic [23:0] e, got;
        horiz = 16'(h); vert = 16'(v); ven = en;
        e = en ? color_of(h, v) : last_exp;
        exp_q.push_back(e);
        last_exp = e;
        @(posedge clk); #1;
        if (frame_tick) tick_cnt++;
        got = {r, g, b};
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL rgb h=%0d v=%0d en=%0b got %h expected %h", h, v, en, got, e);
        end
    endtask

    task automatic do_reset;
        rst = 1'b1; ven = 1'b0; sm_en = 1'b0;
        horiz = 16'd0; vert = 16'd0; sm_h = 16'd0; sm_v = 16'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic check_pos(input string tag);
        checks++;
        if (xp !== 16'(m_x) || yp !== 16'(m_y) || dxo !== m_dx || dyo !== m_dy ||
            bounce !== 8'(m_bounce)) begin
            errors++;
            $display("FAIL %s pos got x=%0d y=%0d dx=%0b dy=%0b bc=%0d expected x=%0d y=%0d dx=%0b dy=%0b bc=%0d",
                     tag, xp, yp, dxo, dyo, bounce, m_x, m_y, m_dx, m_dy, m_bounce);
        end
    endtask

    // one frame: vert_count held at V_ACTIVE for three lines, then line 0
    task automatic do_frame(input string tag);
        tick_cnt = 0;
        apply(0, 480, 1'b1);
        apply(0, 480, 1'b1);
        model_step();
        apply(0, 480, 1'b1);
        apply(0, 0, 1'b1);
        checks++;
        if (tick_cnt != 1) begin
            errors++;
            $display("FAIL %s frame_tick count got %0d expected 1", tag, tick_cnt);
        end
        check_pos(tag);
    endtask

    task automatic small_frame;
        sm_en = 1'b1; sm_h = 16'd0; sm_v = 16'd11;
        repeat (3) begin @(posedge clk); #1; end
        sm_v = 16'd0;
        @(posedge clk); #1;
        sm_en = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if ({r, g, b} !== 24'h0 || frame_tick !== 1'b0 || bounce !== 8'd0 || st !== 2'd0 ||
            xp !== 16'd0 || yp !== 16'd0 || dxo !== 1'b1 || dyo !== 1'b1) begin
            errors++;
            $display("FAIL reset_state got rgb=%h tick=%0b bc=%0d st=%0d x=%0d y=%0d dx=%0b dy=%0b",
                     {r, g, b}, frame_tick, bounce, st, xp, yp, dxo, dyo);
        end
        apply(0, 0, 1'b1);
        rst = 1'b1;
        #1;
        checks++;
        if ({r, g, b} !== 24'h0) begin
            errors++;
            $display("FAIL async_reset_rgb got %h expected 000000", {r, g, b});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_pixels;
        apply(0, 0, 1'b1);
        apply(100, 100, 1'b1);
        apply(700, 10, 1'b1);
        apply(31, 31, 1'b1);
        apply(32, 0, 1'b1);
        apply(0, 32, 1'b1);
        apply(639, 479, 1'b1);
        apply(640, 0, 1'b1);
        apply(5, 480, 1'b1);
        apply(65535, 65535, 1'b1);
    endtask

    task automatic test_first_frame;
        do_frame("first_frame");
        checks++;
        if (xp !== 16'd2 || yp !== 16'd2) begin
            errors++;
            $display("FAIL first_frame_pos got x=%0d y=%0d expected 2 2", xp, yp);
        end
    endtask

    task automatic test_hold;
        logic [1:0] st0;
        apply(0, 0, 1'b1);
        st0 = st;
        for (int i = 0; i < 10; i++) begin
            apply(0, 480, 1'b0);
            checks++;
            if (st !== st0) begin
                errors++;
                $display("FAIL hold_state got %0d expected %0d", st, st0);
            end
        end
    endtask

    task automatic test_reset_in_move;
        horiz = 16'd0; vert = 16'd480; ven = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (st !== 2'd1 || frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL enter_move got st=%0d tick=%0b expected 1 1", st, frame_tick);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (xp !== 16'd0 || yp !== 16'd0 || frame_tick !== 1'b0 || st !== 2'd0 || bounce !== 8'd0) begin
            errors++;
            $display("FAIL reset_in_move got x=%0d y=%0d tick=%0b st=%0d bc=%0d expected 0 0 0 0 0",
                     xp, yp, frame_tick, st, bounce);
        end
        ven = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        do_frame("after_reset_frame");
    endtask

    task automatic test_bounce_x;
        do_reset();
        for (int f = 1; f <= 304; f++) do_frame("run");
        checks++;
        if (xp !== 16'd608 || dxo !== 1'b1 || bounce !== 8'd1) begin
            errors++;
            $display("FAIL frame304 got x=%0d dx=%0b bc=%0d expected 608 1 1", xp, dxo, bounce);
        end
        do_frame("frame305");
        checks++;
        if (xp !== 16'd608 || dxo !== 1'b0 || bounce !== 8'd2) begin
            errors++;
            $display("FAIL frame305 got x=%0d dx=%0b bc=%0d expected 608 0 2", xp, dxo, bounce);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 60; i++) begin
            apply(int'($urandom_range(0, 700)), int'($urandom_range(0, 479)), 1'b1);
        end
        for (int i = 0; i < 20; i++) begin
            apply(m_x + int'($urandom_range(0, 40)) - 4, m_y + int'($urandom_range(0, 40)) - 4,
                  ($urandom_range(0, 3) != 0));
        end
    endtask

    task automatic test_corner;
        int xs[6];
        int bs[6];
        xs = '{3, 6, 7, 4, 1, 0};
        bs = '{0, 0, 1, 1, 1, 2};
        for (int f = 0; f < 6; f++) begin
            small_frame();
            checks++;
            if (sm_x !== 16'(xs[f]) || sm_y !== 16'(xs[f]) || sm_bounce !== 8'(bs[f])) begin
                errors++;
                $display("FAIL corner_frame%0d got x=%0d y=%0d bc=%0d expected %0d %0d %0d",
                         f + 1, sm_x, sm_y, sm_bounce, xs[f], xs[f], bs[f]);
            end
        end
        checks++;
        if (sm_dx !== 1'b1 || sm_dy !== 1'b1) begin
            errors++;
            $display("FAIL corner_dirs got dx=%0b dy=%0b expected 1 1", sm_dx, sm_dy);
        end
    endtask

    initial begin
        rst = 1'b1; ven = 1'b0; horiz = 16'd0; vert = 16'd0;
        sm_en = 1'b0; sm_h = 16'd0; sm_v = 16'd0;
        model_reset();
        test_reset();
        test_pixels();
        test_first_frame();
        test_hold();
        test_reset_in_move();
        test_bounce_x();
        test_back_to_back();
        test_corner();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
